// File: rtl/instr_execute_div.sv
// rtl/instr_execute_div.sv - RV32M DIV/DIVU/REM/REMU unit for the EX stage.
// It uses a 32-step restoring divider and stalls the pipeline until the result is written.
module instr_execute_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        ied_jump_flag_in,
  input  logic [31:0] ied_instr_in,
  input  logic [31:0] ied_op1_in,
  input  logic [31:0] ied_op2_in,
  input  logic [4:0]  ied_write_addr_in,
  output logic        ied_hold_flag_out,
  output logic [31:0] ied_result_out,
  output logic [4:0]  ied_write_addr_out,
  output logic        ied_wen_out
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state, next_state;
  logic [2:0]  funct3;
  logic        is_div, is_signed, is_rem;
  logic        div_by_zero, overflow, special, start;
  logic [31:0] special_res, op1_mag, op2_mag;

  logic [1:0]  f3_q;
  logic [4:0]  rd_q;
  logic [31:0] divisor_q, quot_q, rem_q;
  logic [5:0]  count_q;
  logic        quot_neg_q, rem_neg_q;

  logic [32:0] shifted, diff;
  logic        step_ge;
  logic [31:0] rem_next, quot_next, quot_fix, rem_fix, final_res;
  logic        unused_instr_bits;

  assign funct3            = ied_instr_in[14:12];
  assign is_div            = (ied_instr_in[6:0] == 7'b0110011) &&
                             (ied_instr_in[31:25] == 7'b0000001) && funct3[2];
  assign is_signed         = ~funct3[0];
  assign is_rem            = funct3[1];
  assign unused_instr_bits = ^{ied_instr_in[24:15], ied_instr_in[11:7]};

  assign div_by_zero = (ied_op2_in == 32'd0);
  assign overflow    = is_signed && (ied_op1_in == 32'h8000_0000) && (ied_op2_in == 32'hFFFF_FFFF);
  assign special     = div_by_zero || overflow;
  assign start       = (state == IDLE) && is_div && !ied_jump_flag_in;

  assign special_res = div_by_zero ? (is_rem ? ied_op1_in : 32'hFFFF_FFFF)
                                   : (is_rem ? 32'd0 : 32'h8000_0000);
  assign op1_mag     = (is_signed && ied_op1_in[31]) ? -ied_op1_in : ied_op1_in;
  assign op2_mag     = (is_signed && ied_op2_in[31]) ? -ied_op2_in : ied_op2_in;

  // One restoring step: shift the next dividend bit into the partial remainder and trial-subtract.
  assign shifted   = {rem_q, quot_q[31]};
  assign diff      = shifted - {1'b0, divisor_q};
  assign step_ge   = ~diff[32];
  assign rem_next  = step_ge ? diff[31:0] : shifted[31:0];
  assign quot_next = {quot_q[30:0], step_ge};
  assign quot_fix  = quot_neg_q ? -quot_next : quot_next;
  assign rem_fix   = rem_neg_q ? -rem_next : rem_next;
  assign final_res = f3_q[1] ? rem_fix : quot_fix;

  always_comb begin
    next_state        = state;
    ied_hold_flag_out = 1'b0;
    case (state)
      IDLE: begin
        if (is_div && !ied_jump_flag_in) begin
          ied_hold_flag_out = 1'b1;
          next_state        = special ? DONE : CALC;
        end
      end
      CALC: begin
        ied_hold_flag_out = 1'b1;
        if (ied_jump_flag_in)        next_state = IDLE;
        else if (count_q == 6'd31)   next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (rst) begin
      ied_hold_flag_out = 1'b0;
      next_state        = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      count_q            <= 6'd0;
      ied_result_out     <= 32'd0;
      ied_write_addr_out <= 5'd0;
      ied_wen_out        <= 1'b0;
    end else begin
      state       <= next_state;
      ied_wen_out <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            f3_q    <= funct3[1:0];
            rd_q    <= ied_write_addr_in;
            count_q <= 6'd0;
            if (special) begin
              ied_result_out     <= special_res;
              ied_write_addr_out <= ied_write_addr_in;
              ied_wen_out        <= (ied_write_addr_in != 5'd0);
            end else begin
              divisor_q  <= op2_mag;
              quot_q     <= op1_mag;
              rem_q      <= 32'd0;
              quot_neg_q <= is_signed && (ied_op1_in[31] ^ ied_op2_in[31]);
              rem_neg_q  <= is_signed && ied_op1_in[31];
            end
          end
        end
        CALC: begin
          if (!ied_jump_flag_in) begin
            quot_q  <= quot_next;
            rem_q   <= rem_next;
            count_q <= count_q + 6'd1;
            if (count_q == 6'd31) begin
              ied_result_out     <= final_res;
              ied_write_addr_out <= rd_q;
              ied_wen_out        <= (rd_q != 5'd0);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_execute_div.sv
// tb/tb_instr_execute_div.sv - scoreboard bench for instr_execute_div.
module tb_instr_execute_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        ied_jump_flag_in;
  logic [31:0] ied_instr_in, ied_op1_in, ied_op2_in;
  logic [4:0]  ied_write_addr_in;
  logic        ied_hold_flag_out;
  logic [31:0] ied_result_out;
  logic [4:0]  ied_write_addr_out;
  logic        ied_wen_out;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  instr_execute_div dut (
    .clk                (clk),
    .rst                (rst),
    .ied_jump_flag_in   (ied_jump_flag_in),
    .ied_instr_in       (ied_instr_in),
    .ied_op1_in         (ied_op1_in),
    .ied_op2_in         (ied_op2_in),
    .ied_write_addr_in  (ied_write_addr_in),
    .ied_hold_flag_out  (ied_hold_flag_out),
    .ied_result_out     (ied_result_out),
    .ied_write_addr_out (ied_write_addr_out),
    .ied_wen_out        (ied_wen_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] mk(input logic [2:0] f3, input logic [4:0] rd);
    return {7'b0000001, 5'd2, 5'd1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb_v, r;
    sa   = a;
    sb_v = b;
    if (b == 32'd0) return f3[1] ? a : 32'hFFFF_FFFF;
    if (!f3[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f3[1] ? 32'd0 : 32'h8000_0000;
      r = f3[1] ? (sa % sb_v) : (sa / sb_v);
      return r;
    end
    return f3[1] ? (a % b) : (a / b);
  endfunction

  always @(negedge clk) begin
    if (ied_wen_out === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_wen", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", ied_result_out, e.res);
        check("write_addr", 32'(ied_write_addr_out), 32'(e.rd));
      end
    end
  end

  // Presents one op, counts hold-high cycles up to DONE, then holds the op
  // through the DONE edge and confirms the unit returns to IDLE.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp_res);
    int lat;
    int cnt;
    lat = ((b == 32'd0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 33;
    ied_instr_in      = mk(f3, rd);
    ied_op1_in        = a;
    ied_op2_in        = b;
    ied_write_addr_in = rd;
    if (rd != 5'd0) sb.push_back('{exp_res, rd});
    #1;
    cnt = 0;
    while (ied_hold_flag_out === 1'b1 && cnt < 40) begin
      cnt++;
      @(posedge clk);
      #1;
    end
    check("hold_cycles", 32'(cnt), 32'(lat));
    check("wen_in_done", 32'(ied_wen_out), 32'(rd != 5'd0));
    @(posedge clk);
    #1;
    ied_instr_in = NOP;
    #1;
    check("no_retrigger", 32'(ied_hold_flag_out), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  f3;
    logic [31:0] a, b;
    logic [4:0]  rd;

    rst               = 1'b1;
    ied_jump_flag_in  = 1'b0;
    ied_instr_in      = mk(3'b101, 5'd3);
    ied_op1_in        = 32'd50;
    ied_op2_in        = 32'd5;
    ied_write_addr_in = 5'd3;
    repeat (2) @(posedge clk);
    #1;
    check("rst_result", ied_result_out, 32'd0);
    check("rst_addr", 32'(ied_write_addr_out), 32'd0);
    check("rst_wen", 32'(ied_wen_out), 32'd0);
    check("rst_hold", 32'(ied_hold_flag_out), 32'd0);
    ied_instr_in = NOP;
    rst          = 1'b0;
    @(posedge clk);
    #2;

    run_op(3'b101, 32'd100, 32'd7, 5'd5, 32'd14);
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFD);
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFF);
    run_op(3'b101, 32'd9, 32'd0, 5'd8, 32'hFFFF_FFFF);
    run_op(3'b111, 32'd9, 32'd0, 5'd9, 32'd9);
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000);
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'd0);
    run_op(3'b100, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 5'd12, 32'd14);
    run_op(3'b110, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 5'd13, 32'hFFFF_FFFE);
    run_op(3'b111, 32'd100, 32'd7, 5'd14, 32'd2);
    run_op(3'b100, 32'd20, 32'd3, 5'd0, 32'd6);
    run_op(3'b101, 32'd1000, 32'd10, 5'd15, 32'd100);
    run_op(3'b101, 32'hFFFF_FFFF, 32'd1, 5'd16, 32'hFFFF_FFFF);

    for (int i = 0; i < 8; i++) begin
      f3 = 3'(4 + $urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom >> $urandom_range(0, 31);
      if (i == 3) b = 32'd0;
      rd = 5'($urandom_range(1, 31));
      run_op(f3, a, b, rd, model(f3, a, b));
    end

    // Flush in CALC cycle 10: no write may follow.
    ied_instr_in      = mk(3'b101, 5'd17);
    ied_op1_in        = 32'd12345;
    ied_op2_in        = 32'd17;
    ied_write_addr_in = 5'd17;
    @(posedge clk);
    repeat (9) @(posedge clk);
    #1;
    check("calc_hold", 32'(ied_hold_flag_out), 32'd1);
    ied_jump_flag_in = 1'b1;
    @(posedge clk);
    #1;
    check("jump_hold", 32'(ied_hold_flag_out), 32'd0);
    check("jump_wen", 32'(ied_wen_out), 32'd0);
    ied_jump_flag_in = 1'b0;
    ied_instr_in     = NOP;
    repeat (40) @(posedge clk);
    #1;
    check("post_jump_hold", 32'(ied_hold_flag_out), 32'd0);

    // Reset mid-CALC with a div op still presented.
    ied_instr_in      = mk(3'b101, 5'd18);
    ied_op1_in        = 32'd999;
    ied_op2_in        = 32'd3;
    ied_write_addr_in = 5'd18;
    repeat (15) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_result", ied_result_out, 32'd0);
    check("midrst_addr", 32'(ied_write_addr_out), 32'd0);
    check("midrst_wen", 32'(ied_wen_out), 32'd0);
    check("midrst_hold", 32'(ied_hold_flag_out), 32'd0);
    rst          = 1'b0;
    ied_instr_in = NOP;
    @(posedge clk);
    #2;
    run_op(3'b101, 32'd999, 32'd3, 5'd19, 32'd333);
    run_op(3'b101, 32'd50, 32'd6, 5'd20, 32'd8);

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
